// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the parking gate controller and its sensors/actuator.
// Statistics counters are present only when PARK_STATS_EN is defined.
interface parking_gate_if #(
  parameter int CNT_W = 4
);
  logic             entry_req;
  logic             exit_req;
  logic             car_passed;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] count;
  logic             at_capacity;
  logic             full_pulse;
  logic             busy;
`ifdef PARK_STATS_EN
  logic [15:0]      total_in;
  logic [15:0]      total_out;
  logic [15:0]      refused;
  logic [15:0]      timeouts;
`endif

  modport master (
    output entry_req, exit_req, car_passed,
    input  gate_open, entry_grant, exit_grant, count, at_capacity, full_pulse, busy
`ifdef PARK_STATS_EN
    , input total_in, total_out, refused, timeouts
`endif
  );

  modport slave (
    input  entry_req, exit_req, car_passed,
    output gate_open, entry_grant, exit_grant, count, at_capacity, full_pulse, busy
`ifdef PARK_STATS_EN
    , output total_in, total_out, refused, timeouts
`endif
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Single-gate parking controller: round-robin entry/exit arbitration, timed open window,
// occupancy tracking and full indication. Optional statistics via PARK_STATS_EN.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 16
) (
  input  logic          CLK,
  input  logic          RST,
  parking_gate_if.slave bus
);

  localparam int               TMR_W    = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_M1   = CNT_W'(CAPACITY - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSE} state_e;
  typedef enum logic {SIDE_ENTRY, SIDE_EXIT} side_e;

  state_e           state_q, state_d;
  side_e            side_q, side_d;
  side_e            ptr_q, ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             at_cap_q;
  logic             full_q, full_d;
  logic             entry_req_q;

  logic entry_rise, elig_entry, elig_exit;
  logic pass_entry, pass_exit, timeout, cause_a, cause_b;

  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    count_d    = count_q;
    pass_entry = 1'b0;
    pass_exit  = 1'b0;
    timeout    = 1'b0;
    cause_a    = 1'b0;
    cause_b    = 1'b0;
    entry_rise = bus.entry_req & ~entry_req_q;
    elig_entry = bus.entry_req & (count_q < CAP);
    elig_exit  = bus.exit_req & (count_q != '0);

    unique case (state_q)
      S_IDLE: begin
        cause_b = entry_rise & at_cap_q;
        if (elig_entry && elig_exit) begin
          side_d  = ptr_q;
          ptr_d   = (ptr_q == SIDE_EXIT) ? SIDE_ENTRY : SIDE_EXIT;
          state_d = S_OPEN;
          timer_d = '0;
        end else if (elig_entry) begin
          side_d  = SIDE_ENTRY;
          state_d = S_OPEN;
          timer_d = '0;
        end else if (elig_exit) begin
          side_d  = SIDE_EXIT;
          state_d = S_OPEN;
          timer_d = '0;
        end
      end
      S_OPEN: begin
        // A pass on the last window cycle still counts; it takes priority over timeout.
        if (bus.car_passed) begin
          state_d = S_CLOSE;
          if (side_q == SIDE_ENTRY) begin
            if (count_q < CAP) begin
              count_d    = count_q + CNT_W'(1);
              pass_entry = 1'b1;
              cause_a    = (count_q == CAP_M1);
            end
          end else if (count_q != '0) begin
            count_d   = count_q - CNT_W'(1);
            pass_exit = 1'b1;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = S_CLOSE;
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CLOSE: begin
        cause_b = entry_rise & at_cap_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Back-to-back causes collapse so the indicator never sees a 2-cycle hold.
    full_d = (cause_a | cause_b) & ~full_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      side_q      <= SIDE_ENTRY;
      ptr_q       <= SIDE_EXIT;
      timer_q     <= '0;
      count_q     <= '0;
      at_cap_q    <= 1'b0;
      full_q      <= 1'b0;
      entry_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      at_cap_q    <= (count_d == CAP);
      full_q      <= full_d;
      entry_req_q <= bus.entry_req;
    end
  end

  assign bus.gate_open   = (state_q == S_OPEN);
  assign bus.entry_grant = (state_q == S_OPEN) && (side_q == SIDE_ENTRY);
  assign bus.exit_grant  = (state_q == S_OPEN) && (side_q == SIDE_EXIT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.count       = count_q;
  assign bus.at_capacity = at_cap_q;
  assign bus.full_pulse  = full_q;

`ifdef PARK_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] total_in_q, total_out_q, refused_q, timeouts_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      total_in_q  <= '0;
      total_out_q <= '0;
      refused_q   <= '0;
      timeouts_q  <= '0;
    end else begin
      if (pass_entry) total_in_q  <= sat_inc(total_in_q);
      if (pass_exit)  total_out_q <= sat_inc(total_out_q);
      if (cause_b)    refused_q   <= sat_inc(refused_q);
      if (timeout)    timeouts_q  <= sat_inc(timeouts_q);
    end
  end

  assign bus.total_in  = total_in_q;
  assign bus.total_out = total_out_q;
  assign bus.refused   = refused_q;
  assign bus.timeouts  = timeouts_q;
`endif

endmodule
